stb_generator: RTL and testbench
================================

# stb_generator

Period-locked strobe generator for the measure unit. It measures the period of an asynchronous comparator output `sig_i` in clock cycles once armed by `run_det_i`. It then regenerates a free-running strobe at that period, phase-aligned to the measured signal, and gates single strobes onto `stb_o` on request.

## Interface
- `T_CNT_WIDTH`, 32, width of period counter and `stb_period_o`.
- `SYNC_STAGES`, 2, synchronizer depth for `sig_i`.
- `clk_i` in 1: single clock (8 ns nominal).
- `arst_i` in 1: reset, asynchronous, active-low.
- `sig_i` in 1: asynchronous comparator output; measured signal.
- `run_det_i` in 1: synchronous; rising edge starts a new period detection.
- `oe_i` in 1: output enable for `stb_o`.
- `stb_req_i` in 1: one-cycle pulse arms one strobe on `stb_o`.
- `stb_o` out 1: requested strobe pulse.
- `stb_valid_o` out 1: marks the cycle in which a requested strobe is issued.
- `debug_stb_o` out 1: free-running regenerated strobe.
- `rdy_o` out 1: period measured, generator running.
- `err_o` out 1: measurement failed.
- `stb_period_o` out `T_CNT_WIDTH`: measured period in clk cycles.

## Operation
- `sig_i` passes through a `SYNC_STAGES` flip-flop synchronizer, then a rising-edge detector producing `sig_rise`.
- FSM states:
  - IDLE: entered at reset.
  - ARM: entered from any state on a `run_det_i` rising edge. Clears `rdy_o`, `err_o` and `stb_period_o`, stops the generator, drops any pending request.
  - COUNT: entered from ARM on the first `sig_rise`. The counter is 1 in the cycle after that edge and increments each cycle.
  - RUN: entered from COUNT on the second `sig_rise`. Latch `stb_period_o` = cycles between the two edges, set `rdy_o`.
  - ERR: entered from COUNT when the counter reaches all-ones before the second edge, or when the measured period is < 4. Sets `err_o` and holds until reset or a new `run_det_i` edge.
- Generator in RUN:
  - Down-counter loads `stb_period_o`−1 in the latch cycle.
  - At 0 it asserts `debug_stb_o` for exactly one cycle and reloads.
  - The first strobe fires P cycles after the second `sig_rise`.
- Request path:
  - A `stb_req_i` pulse sets a pending flag; a request arriving while already pending is absorbed.
  - On the next generator tick with the flag set: `stb_valid_o`=1 for that cycle, `stb_o`=`oe_i` for that cycle, flag cleared.
  - A `stb_req_i` coincident with a tick is served on that tick.
  - Requests outside RUN stay pending until RUN or until ARM clears them.
- `sig_i` edges in RUN/ERR/IDLE are ignored.

## Timing
- Reset values: all outputs 0, `stb_period_o`=0, FSM IDLE.
- `sig_i` to `sig_rise` latency: `SYNC_STAGES`+1 cycles. The same latency applies to both edges, so it cancels in the period.
- Measured P = floor or ceil of the true period / T_clk.
  - Regenerated period error is < 1 clk period.
  - Phase error is bounded by synchronizer latency + 1 cycle.
- `sig_i` high and low times must each be ≥ 2 clk cycles; minimum supported period is 4 cycles.
- `run_det_i` and `arst_i` may arrive at any time, including mid-measurement or mid-RUN. The block restarts cleanly with no spurious strobe.
- Outputs are registered; `stb_o`, `stb_valid_o` and `debug_stb_o` are aligned in the same cycle.

## Structure
- Package `stb_gen_pkg`:
  - FSM state enum (IDLE, ARM, COUNT, RUN, ERR).
  - `MIN_PERIOD` = 4.
  - Default `T_CNT_WIDTH`.
- Sub-module `sync_ff`: parameterized N-stage synchronizer with async active-low reset.
- Counter, FSM and generator live in the top module.

## Test plan
All scenarios use an 8 ns clk.
- Pulse train with 20 ns high width at periods 100, 20000, 200000 and 1333333 ns, random start phase. Required response:
  - `rdy_o` asserts.
  - `stb_period_o` ∈ {12,13}, {2500}, {25000}, {166666,166667} respectively (±1 for the exact-multiple periods).
  - Interval between the 10th and 11th `debug_stb_o` rising edges differs from the true period by < 8 ns.
- `T_CNT_WIDTH`=8, period 3000 ns (375 cycles) -> `err_o`=1, `rdy_o`=0, no `debug_stb_o`.
- In RUN with P=2500: `stb_req_i` pulse with `oe_i`=1 -> exactly one `stb_o` and `stb_valid_o` pulse, coincident with the next `debug_stb_o`. With `oe_i`=0 -> `stb_valid_o` pulses, `stb_o` stays 0.
- `run_det_i` re-pulsed mid-RUN, then a new 200000 ns signal -> `rdy_o` drops within 1 cycle, `debug_stb_o` stops, new `stb_period_o`=25000.
- `arst_i` low mid-COUNT -> all outputs 0 immediately; FSM IDLE until the next `run_det_i`.
- `sig_i` held low after ARM -> `rdy_o` stays 0, `err_o` stays 0, FSM remains in ARM.

Source files
------------

// File: rtl/stb_generator_pkg.sv
// Shared types and constants for the period-locked strobe generator.
package stb_gen_pkg;

   // Measurement / generator control states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_COUNT,
      ST_RUN,
      ST_ERR
   } state_e;

   // Shortest period (in clk cycles) the generator will lock to
   localparam int MIN_PERIOD      = 4;
   // Default period counter width
   localparam int T_CNT_WIDTH_DEF = 32;

endpackage

// File: rtl/stb_generator_if.sv
// Signal bundle between the strobe generator and its user.
interface stb_generator_if
   import stb_gen_pkg::*;
#(
   parameter int T_CNT_WIDTH = T_CNT_WIDTH_DEF
);
   logic                   sig_i;
   logic                   run_det_i;
   logic                   oe_i;
   logic                   stb_req_i;
   logic                   stb_o;
   logic                   stb_valid_o;
   logic                   debug_stb_o;
   logic                   rdy_o;
   logic                   err_o;
   logic [T_CNT_WIDTH-1:0] stb_period_o;

   modport master (
      output sig_i, run_det_i, oe_i, stb_req_i,
      input  stb_o, stb_valid_o, debug_stb_o, rdy_o, err_o, stb_period_o
   );

   modport slave (
      input  sig_i, run_det_i, oe_i, stb_req_i,
      output stb_o, stb_valid_o, debug_stb_o, rdy_o, err_o, stb_period_o
   );
endinterface

// File: rtl/sync_ff.sv
// N-stage flip-flop synchronizer for a single asynchronous bit.
module sync_ff #(
   parameter int N = 2
) (
   input  logic clk_i,
   input  logic arst_i,
   input  logic d_i,
   output logic q_o
);
   logic [N-1:0] sync_q, sync_d;

   // Shift the input in at the LSB; the MSB is the synchronized value
   always_comb begin
      sync_d = (sync_q << 1) | N'(d_i);
   end

   // Synchronizer stages
   always_ff @(posedge clk_i or negedge arst_i) begin
      if (!arst_i) sync_q <= '0;
      else         sync_q <= sync_d;
   end

   assign q_o = sync_q[N-1];
endmodule

// File: rtl/stb_generator.sv
// Measures the period of sig_i in clk cycles, then regenerates a
// free-running strobe at that period and gates requested strobes onto stb_o.
module stb_generator
   import stb_gen_pkg::*;
#(
   parameter int T_CNT_WIDTH = T_CNT_WIDTH_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk_i,
   input  logic            arst_i,
   stb_generator_if.slave  bus
);
   localparam logic [T_CNT_WIDTH-1:0] ONE  = T_CNT_WIDTH'(1);
   localparam logic [T_CNT_WIDTH-1:0] PMIN = T_CNT_WIDTH'(MIN_PERIOD);

   logic                   sig_s;
   logic                   sig_prev_q, sig_prev_d;
   logic                   rise_q, rise_d;
   logic                   run_prev_q, run_prev_d;
   logic                   run_rise;
   state_e                 state_q, state_d;
   logic [T_CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [T_CNT_WIDTH-1:0] gen_q, gen_d;
   logic [T_CNT_WIDTH-1:0] period_q, period_d;
   logic                   rdy_q, rdy_d;
   logic                   err_q, err_d;
   logic                   pend_q, pend_d;
   logic                   dbg_q, dbg_d;
   logic                   vld_q, vld_d;
   logic                   stb_q, stb_d;
   logic                   tick, served;

   sync_ff #(.N(SYNC_STAGES)) u_sync (
      .clk_i (clk_i),
      .arst_i(arst_i),
      .d_i   (bus.sig_i),
      .q_o   (sig_s)
   );

   // Edge detection: registered sig rise (same latency for every edge) and run_det rise
   always_comb begin
      sig_prev_d = sig_s;
      rise_d     = sig_s & ~sig_prev_q;
      run_prev_d = bus.run_det_i;
      run_rise   = bus.run_det_i & ~run_prev_q;
   end

   // FSM next state, period counter, latched period and generator down-counter
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      gen_d    = gen_q;
      period_d = period_q;
      rdy_d    = rdy_q;
      err_d    = err_q;
      if (run_rise) begin
         // A fresh arm wins over everything and wipes the previous result
         state_d  = ST_ARM;
         cnt_d    = '0;
         gen_d    = '0;
         period_d = '0;
         rdy_d    = 1'b0;
         err_d    = 1'b0;
      end else begin
         case (state_q)
            ST_ARM: begin
               if (rise_q) begin
                  state_d = ST_COUNT;
                  cnt_d   = ONE;
               end
            end
            ST_COUNT: begin
               if (rise_q) begin
                  if (cnt_q < PMIN) begin
                     state_d = ST_ERR;
                     err_d   = 1'b1;
                  end else begin
                     state_d  = ST_RUN;
                     period_d = cnt_q;
                     rdy_d    = 1'b1;
                     gen_d    = cnt_q - ONE;
                  end
               end else if (cnt_q == '1) begin
                  state_d = ST_ERR;
                  err_d   = 1'b1;
               end else begin
                  cnt_d = cnt_q + ONE;
               end
            end
            ST_RUN: begin
               gen_d = (gen_q == '0) ? period_q - ONE : gen_q - ONE;
            end
            default: ;
         endcase
      end
   end

   // Strobe tick and request service; outputs are registered one cycle on,
   // so the tick is taken when the down-counter is about to hit zero
   always_comb begin
      tick   = (state_q == ST_RUN) && (state_d == ST_RUN) && (gen_q == ONE);
      served = tick && (pend_q || bus.stb_req_i);
      dbg_d  = tick;
      vld_d  = served;
      stb_d  = served && bus.oe_i;
      if (run_rise)    pend_d = 1'b0;
      else if (served) pend_d = 1'b0;
      else             pend_d = pend_q || bus.stb_req_i;
   end

   // State and output registers
   always_ff @(posedge clk_i or negedge arst_i) begin
      if (!arst_i) begin
         sig_prev_q <= 1'b0;
         rise_q     <= 1'b0;
         run_prev_q <= 1'b0;
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         gen_q      <= '0;
         period_q   <= '0;
         rdy_q      <= 1'b0;
         err_q      <= 1'b0;
         pend_q     <= 1'b0;
         dbg_q      <= 1'b0;
         vld_q      <= 1'b0;
         stb_q      <= 1'b0;
      end else begin
         sig_prev_q <= sig_prev_d;
         rise_q     <= rise_d;
         run_prev_q <= run_prev_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         gen_q      <= gen_d;
         period_q   <= period_d;
         rdy_q      <= rdy_d;
         err_q      <= err_d;
         pend_q     <= pend_d;
         dbg_q      <= dbg_d;
         vld_q      <= vld_d;
         stb_q      <= stb_d;
      end
   end

   assign bus.stb_o        = stb_q;
   assign bus.stb_valid_o  = vld_q;
   assign bus.debug_stb_o  = dbg_q;
   assign bus.rdy_o        = rdy_q;
   assign bus.err_o        = err_q;
   assign bus.stb_period_o = period_q;
endmodule

// File: tb/tb_stb_generator.sv
// Bench for stb_generator. One time unit = 0.5 ns: clk edges fall on
// multiples of 8 units, sig_i edges on odd units, so they never coincide.
module tb_stb_generator;
   logic clk = 1'b0;
   logic arst_n = 1'b0;
   logic sig = 1'b0, run_det = 1'b0, oe = 1'b0, req = 1'b0, run_det8 = 1'b0;
   int   total = 0, bad = 0;

   stb_generator_if #(.T_CNT_WIDTH(32)) bus  ();
   stb_generator_if #(.T_CNT_WIDTH(8))  bus8 ();

   assign bus.sig_i      = sig;
   assign bus.run_det_i  = run_det;
   assign bus.oe_i       = oe;
   assign bus.stb_req_i  = req;
   assign bus8.sig_i     = sig;
   assign bus8.run_det_i = run_det8;
   assign bus8.oe_i      = 1'b0;
   assign bus8.stb_req_i = 1'b0;

   stb_generator #(.T_CNT_WIDTH(32), .SYNC_STAGES(2)) dut (
      .clk_i(clk), .arst_i(arst_n), .bus(bus));
   stb_generator #(.T_CNT_WIDTH(8), .SYNC_STAGES(2)) dut8 (
      .clk_i(clk), .arst_i(arst_n), .bus(bus8));

   always #8 clk = ~clk;

   // Pulse-train source, 1 ns resolution: high for hi_ns at the start of each period
   longint k = 0, k0 = 0;
   int     per_ns = 100, hi_ns = 20;
   bit     gen_en = 1'b0;
   initial begin
      #1;
      forever begin
         sig = gen_en && (k >= k0) && (((k - k0) % per_ns) < hi_ns);
         k++;
         #2;
      end
   end

   // Output monitor
   int     dbg_cnt = 0, vld_cnt = 0, stb_cnt = 0, vnd_cnt = 0, spur = 0, dbg8_cnt = 0, vld_idx = 0;
   longint dbg_t[$];
   always @(negedge clk) begin
      if (bus.debug_stb_o === 1'b1) begin
         dbg_cnt++;
         dbg_t.push_back($time);
         if (bus.rdy_o !== 1'b1) spur++;
      end
      if (bus.stb_valid_o === 1'b1) begin
         vld_cnt++;
         vld_idx = dbg_cnt;
         if (bus.debug_stb_o !== 1'b1) vnd_cnt++;
      end
      if (bus.stb_o === 1'b1) begin
         stb_cnt++;
         if (bus.stb_valid_o !== 1'b1) vnd_cnt++;
      end
      if (bus8.debug_stb_o === 1'b1) dbg8_cnt++;
   end

   initial begin
      #(98000 * 16);
      $display("FAIL watchdog: simulation ran past the cycle budget");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_rng(input string tag, input longint obs, input longint lo, input longint hi);
      total++;
      assert (obs >= lo && obs <= hi) else begin
         bad++;
         $error("FAIL %s: got %0d want %0d..%0d", tag, obs, lo, hi);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic arm();
      run_det = 1'b1; step(); run_det = 1'b0; step();
   endtask

   task automatic pulse_req();
      req = 1'b1; step(); req = 1'b0;
   endtask

   task automatic quiet();
      gen_en = 1'b0;
      repeat (6) step();
   endtask

   task automatic start_sig(input int per, input int hi);
      per_ns = per;
      hi_ns  = hi;
      k0     = k + longint'($urandom_range(0, per - 1));
      gen_en = 1'b1;
   endtask

   task automatic wait_rdy(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max && !ok; i++) begin
         step();
         if (bus.rdy_o === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic wait_err(input int max, input bit use8, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max && !ok; i++) begin
         step();
         if ((use8 ? bus8.err_o : bus.err_o) === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic wait_dbg(input int target, input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max && !ok; i++) begin
         step();
         if (dbg_cnt >= target) ok = 1'b1;
      end
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_rdy"},    bus.rdy_o,        0);
      chk({tag, "_err"},    bus.err_o,        0);
      chk({tag, "_period"}, bus.stb_period_o, 0);
      chk({tag, "_dbg"},    bus.debug_stb_o,  0);
      chk({tag, "_stb"},    bus.stb_o,        0);
      chk({tag, "_vld"},    bus.stb_valid_o,  0);
      chk({tag, "_err8"},   bus8.err_o,       0);
   endtask

   initial begin
      bit     ok;
      int     t, base, idx, v0, s0, d0, sp0;
      longint iv, diff;

      // Reset state
      repeat (3) step();
      chk_zero_outputs("reset");
      arst_n = 1'b1;
      step();

      // Boundary: period of exactly MIN_PERIOD cycles locks
      quiet(); arm(); start_sig(32, 16);
      wait_rdy(60, ok);
      chk("p4_rdy", ok, 1);
      chk("p4_period", bus.stb_period_o, 4);
      chk("p4_err", bus.err_o, 0);

      // Boundary: 3-cycle period is rejected
      quiet(); arm(); start_sig(24, 12);
      wait_err(60, 1'b0, ok);
      chk("p3_err", ok, 1);
      chk("p3_rdy", bus.rdy_o, 0);

      // 100 ns, then random periods; regenerated interval within one clk of true
      for (int i = 0; i < 5; i++) begin
         t = (i == 0) ? 100 : int'($urandom_range(40, 2000));
         quiet();
         base = dbg_cnt; v0 = vld_cnt; s0 = stb_cnt;
         arm();
         if (i == 0) begin
            // Request made before RUN stays pending until the first strobe
            oe = 1'b1;
            pulse_req();
         end
         start_sig(t, 20);
         wait_rdy(3 * (t / 8) + 60, ok);
         chk("rnd_rdy", ok, 1);
         chk_rng("rnd_period", longint'(bus.stb_period_o), t / 8, (t + 7) / 8);
         wait_dbg(base + 11, 12 * (t / 8 + 1) + 40, ok);
         chk("rnd_dbg11", ok, 1);
         if (ok) begin
            iv   = (dbg_t[base + 10] - dbg_t[base + 9]) / 2;
            diff = iv - t;
            if (diff < 0) diff = -diff;
            chk_rng("rnd_interval_err_ns", diff, 0, 7);
         end
         chk("rnd_vld_count", vld_cnt - v0, (i == 0) ? 1 : 0);
         chk("rnd_stb_count", stb_cnt - s0, (i == 0) ? 1 : 0);
         if (i == 0) chk("pre_run_req_idx", vld_idx, base + 1);
      end

      // P = 2500 cycles (20000 ns)
      quiet(); arm(); start_sig(20000, 20);
      wait_rdy(7600, ok);
      chk("p2500_rdy", ok, 1);
      chk_rng("p2500_period", longint'(bus.stb_period_o), 2499, 2501);

      // Request with oe=1: one stb_o + stb_valid_o on the next strobe only
      oe = 1'b1;
      wait_dbg(dbg_cnt + 1, 2600, ok);
      repeat ($urandom_range(1, 100)) step();
      idx = dbg_cnt; v0 = vld_cnt; s0 = stb_cnt;
      pulse_req();
      wait_dbg(idx + 2, 5100, ok);
      chk("req_oe1_wait", ok, 1);
      chk("req_oe1_vld", vld_cnt - v0, 1);
      chk("req_oe1_stb", stb_cnt - s0, 1);
      chk("req_oe1_idx", vld_idx, idx + 1);

      // Request with oe=0: valid pulses, stb_o stays low
      oe = 1'b0;
      wait_dbg(dbg_cnt + 1, 2600, ok);
      repeat ($urandom_range(1, 100)) step();
      idx = dbg_cnt; v0 = vld_cnt; s0 = stb_cnt;
      pulse_req();
      wait_dbg(idx + 2, 5100, ok);
      chk("req_oe0_vld", vld_cnt - v0, 1);
      chk("req_oe0_stb", stb_cnt - s0, 0);
      chk("req_oe0_idx", vld_idx, idx + 1);

      // Two requests before a tick are absorbed into one
      oe = 1'b1;
      wait_dbg(dbg_cnt + 1, 2600, ok);
      idx = dbg_cnt; v0 = vld_cnt; s0 = stb_cnt;
      pulse_req();
      repeat (3) step();
      pulse_req();
      wait_dbg(idx + 2, 5100, ok);
      chk("req_absorb_vld", vld_cnt - v0, 1);
      chk("req_absorb_stb", stb_cnt - s0, 1);

      // Re-arm mid-RUN with a pending request; new signal 2000 ns
      wait_dbg(dbg_cnt + 1, 2600, ok);
      pulse_req();
      quiet();
      v0 = vld_cnt; sp0 = spur;
      arm();
      chk("rearm_rdy_drop", bus.rdy_o, 0);
      chk("rearm_period_clr", bus.stb_period_o, 0);
      start_sig(2000, 20);
      wait_rdy(800, ok);
      chk("rearm_rdy", ok, 1);
      chk("rearm_period", bus.stb_period_o, 250);
      base = dbg_cnt;
      wait_dbg(base + 3, 800, ok);
      chk("rearm_pend_dropped", vld_cnt - v0, 0);
      chk("rearm_no_spur", spur - sp0, 0);

      // Narrow counter: 375-cycle period overflows an 8-bit counter
      quiet();
      run_det8 = 1'b1; step(); run_det8 = 1'b0;
      start_sig(3000, 20);
      wait_err(1200, 1'b1, ok);
      chk("w8_err", ok, 1);
      chk("w8_rdy", bus8.rdy_o, 0);
      chk("w8_no_dbg", dbg8_cnt, 0);

      // Async reset in the middle of COUNT
      quiet(); arm(); start_sig(20000, 20);
      for (int i = 0; i < 3000 && k < k0 + 200; i++) step();
      repeat (10) step();
      #3 arst_n = 1'b0;
      #1 chk_zero_outputs("arst");
      step();
      arst_n = 1'b1;
      d0 = dbg_cnt;
      repeat (3000) step();
      chk("arst_idle_rdy", bus.rdy_o, 0);
      chk("arst_idle_err", bus.err_o, 0);
      chk("arst_idle_dbg", dbg_cnt - d0, 0);

      // sig_i held low after ARM: nothing happens, then a signal still locks
      quiet(); arm();
      repeat (600) step();
      chk("low_rdy", bus.rdy_o, 0);
      chk("low_err", bus.err_o, 0);
      start_sig(200, 20);
      wait_rdy(150, ok);
      chk("low_then_rdy", ok, 1);
      chk("low_then_period", bus.stb_period_o, 25);

      chk("vld_without_dbg", vnd_cnt, 0);
      chk("dbg_without_rdy", spur, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
